// File: rtl/i2s_transmitter.sv
`timescale 1ns/1ps
// I2S transmitter: AXI-Stream sample FIFO feeding a 32-bit-slot serialiser clocked by an external sck/ws.
// Define I2S_TRANSMITTER_UNDERFLOW_COUNT_EN to add the saturating 16-bit underflow_count output.
module i2s_transmitter #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  input  logic        sck,
  input  logic        ws,
  output logic        sd,
  output logic        underflow
`ifdef I2S_TRANSMITTER_UNDERFLOW_COUNT_EN
  ,
  output logic [15:0] underflow_count
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = DATA_WIDTH + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_width
    $error("DATA_WIDTH must be in 1..32");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT
  } state_e;

  // Sample FIFO
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          rdy_en_q;
  logic          full, empty, push, pop;
  logic [EW-1:0] head;
  logic [31:0]   tdata_unused;

  assign empty         = (wr_ptr_q == rd_ptr_q);
  assign full          = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign s_axis_tready = rdy_en_q && !full;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign tdata_unused  = s_axis_tdata << DATA_WIDTH;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tdata[31 -: DATA_WIDTH]};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdy_en_q <= 1'b1;
    end
  end

  // sck/ws synchronisers; sck_s3_q is the previous synchronised sck for edge detection
  logic sck_s1_q, sck_s2_q, sck_s3_q;
  logic ws_s1_q, ws_s2_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sck_s1_q <= 1'b0;
      sck_s2_q <= 1'b0;
      sck_s3_q <= 1'b0;
      ws_s1_q  <= 1'b0;
      ws_s2_q  <= 1'b0;
    end else begin
      sck_s1_q <= sck;
      sck_s2_q <= sck_s1_q;
      sck_s3_q <= sck_s2_q;
      ws_s1_q  <= ws;
      ws_s2_q  <= ws_s1_q;
    end
  end

  // Slot FSM and serialiser
  state_e      state_q, state_d;
  logic        ws_prev_q, ws_prev_d;
  logic        ws_seen_q, ws_seen_d;
  logic [31:0] shreg_q, shreg_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        sd_q, sd_d;
  logic        underflow_q, underflow_d;
  logic        sck_fall, boundary, head_match, slot_underflow;

  // The first falling edge after reset only records ws, so a boundary needs a real transition.
  assign sck_fall       = sck_s3_q && !sck_s2_q;
  assign boundary       = sck_fall && ws_seen_q && (ws_s2_q != ws_prev_q);
  assign head_match     = !empty && (head[EW-1] == ws_prev_q);
  assign pop            = (state_q == S_LOAD) && head_match;
  assign slot_underflow = (state_q == S_LOAD) && !head_match;

  always_comb begin
    state_d     = state_q;
    ws_prev_d   = ws_prev_q;
    ws_seen_d   = ws_seen_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    sd_d        = sd_q;
    underflow_d = underflow_q || slot_underflow;

    if (sck_fall) begin
      ws_prev_d = ws_s2_q;
      ws_seen_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        sd_d = 1'b0;
        if (boundary) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        shreg_d   = head_match ? (32'(head[DATA_WIDTH-1:0]) << (32 - DATA_WIDTH)) : '0;
        bit_cnt_d = '0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (sck_fall) begin
          // A boundary edge still carries the previous slot's last bit (one-bit delay).
          if (bit_cnt_q != 6'd32) begin
            sd_d      = shreg_q[31];
            shreg_d   = {shreg_q[30:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 6'd1;
          end else begin
            sd_d = 1'b0;
          end
          if (boundary) begin
            state_d = S_LOAD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      ws_prev_q   <= 1'b0;
      ws_seen_q   <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      sd_q        <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ws_prev_q   <= ws_prev_d;
      ws_seen_q   <= ws_seen_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      sd_q        <= sd_d;
      underflow_q <= underflow_d;
    end
  end

  assign sd        = sd_q;
  assign underflow = underflow_q;

`ifdef I2S_TRANSMITTER_UNDERFLOW_COUNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (slot_underflow && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underflow_count = ucnt_q;
`endif

endmodule

// File: tb/tb_i2s_transmitter.sv
`timescale 1ns/1ps
// Directed bench for i2s_transmitter: sck at clk_in/16, 32-bit slots, sd captured once per bit period.
module tb_i2s_transmitter;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tlast = 1'b0;
  logic        sck = 1'b1;
  logic        ws = 1'b1;
  logic        sd;
  logic        underflow;
`ifdef I2S_TRANSMITTER_UNDERFLOW_COUNT_EN
  logic [15:0] underflow_count;
`endif

  int errors = 0;
  int checks = 0;
  logic rx[$];
  logic accepted;

  i2s_transmitter #(.DATA_WIDTH(24), .FIFO_DEPTH(4)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .sck           (sck),
    .ws            (ws),
    .sd            (sd),
    .underflow     (underflow)
`ifdef I2S_TRANSMITTER_UNDERFLOW_COUNT_EN
    ,
    .underflow_count (underflow_count)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One sck period: falling edge (ws changes with it), sd sampled mid-period.
  task automatic sck_bit(input logic w);
    sck = 1'b0;
    ws  = w;
    #80;
    rx.push_back(sd);
    sck = 1'b1;
    #80;
  endtask

  task automatic run_slot(input logic w);
    for (int i = 0; i < 32; i++) sck_bit(w);
  endtask

  task automatic align_sck();
    @(negedge clk_in);
    #2;
  endtask

  // Word transmitted in the slot whose boundary edge produced sample rx[base].
  function automatic logic [31:0] get_word(input int base);
    logic [31:0] w;
    w = '0;
    for (int i = 1; i <= 32; i++) begin
      if (base + i < rx.size()) w = {w[30:0], rx[base + i]};
      else                      w = {w[30:0], 1'bx};
    end
    return w;
  endfunction

  task automatic push(input logic [31:0] d, input logic last, input string tag);
    logic ok;
    ok = 1'b0;
    @(negedge clk_in);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    for (int i = 0; i < 50; i++) begin
      if (s_axis_tready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    check(tag, {31'd0, ok}, 32'd1);
    @(posedge clk_in);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n_in      = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    check("rst_sd", {31'd0, sd}, 32'd0);
    check("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    check("rst_underflow", {31'd0, underflow}, 32'd0);
`ifdef I2S_TRANSMITTER_UNDERFLOW_COUNT_EN
    check("rst_ucnt", {16'd0, underflow_count}, 32'd0);
`endif
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    check("rel_tready_0", {31'd0, s_axis_tready}, 32'd0);
    @(posedge clk_in);
    #1;
    check("rel_tready_1", {31'd0, s_axis_tready}, 32'd1);
    rx.delete();
  endtask

  initial begin
    // Basic left/right transfer
    do_reset();
    push(32'hABCDEF00, 1'b0, "s1_push_l");
    push(32'h12345600, 1'b1, "s1_push_r");
    align_sck();
    run_slot(1'b1);
    run_slot(1'b0);
    run_slot(1'b1);
    check("s1_underflow_0", {31'd0, underflow}, 32'd0);
    run_slot(1'b0);
    check("s1_idle_zero", {31'd0, (rx[0] | rx[10] | rx[31] | rx[32])}, 32'd0);
    check("s1_left_word", get_word(32), 32'hABCDEF00);
    check("s1_right_word", get_word(64), 32'h12345600);
    check("s1_underflow_1", {31'd0, underflow}, 32'd1);

    // FIFO full back-pressure and ordering
    do_reset();
    push(32'h10203000, 1'b0, "s2_push1");
    push(32'h40506000, 1'b1, "s2_push2");
    push(32'h70809000, 1'b0, "s2_push3");
    push(32'hA0B0C000, 1'b1, "s2_push4");
    @(negedge clk_in);
    check("s2_full_tready", {31'd0, s_axis_tready}, 32'd0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hD0E0F000;
    s_axis_tlast  = 1'b0;
    repeat (4) @(negedge clk_in);
    check("s2_held_tready", {31'd0, s_axis_tready}, 32'd0);
    accepted = 1'b0;
    fork
      begin
        align_sck();
        run_slot(1'b1);
        run_slot(1'b0);
        run_slot(1'b1);
        run_slot(1'b0);
        run_slot(1'b1);
        run_slot(1'b0);
        check("s2_underflow_0", {31'd0, underflow}, 32'd0);
        run_slot(1'b1);
      end
      begin
        for (int i = 0; i < 3000 && !accepted; i++) begin
          @(negedge clk_in);
          if (s_axis_tready) begin
            @(posedge clk_in);
            #1;
            s_axis_tvalid = 1'b0;
            accepted = 1'b1;
          end
        end
      end
    join
    s_axis_tvalid = 1'b0;
    check("s2_fifth_accepted", {31'd0, accepted}, 32'd1);
    check("s2_word1", get_word(32), 32'h10203000);
    check("s2_word2", get_word(64), 32'h40506000);
    check("s2_word3", get_word(96), 32'h70809000);
    check("s2_word4", get_word(128), 32'hA0B0C000);
    check("s2_word5", get_word(160), 32'hD0E0F000);

    // Empty FIFO underflow
    do_reset();
    align_sck();
    run_slot(1'b1);
    run_slot(1'b0);
    check("s3_underflow", {31'd0, underflow}, 32'd1);
`ifdef I2S_TRANSMITTER_UNDERFLOW_COUNT_EN
    check("s3_ucnt_1", {16'd0, underflow_count}, 32'd1);
`endif
    run_slot(1'b1);
    check("s3_left_zero", get_word(32), 32'h00000000);
`ifdef I2S_TRANSMITTER_UNDERFLOW_COUNT_EN
    check("s3_ucnt_2", {16'd0, underflow_count}, 32'd2);
`endif

    // Channel mismatch: right word waits out the left slot
    do_reset();
    push(32'h5A5A5A00, 1'b1, "s4_push_r");
    align_sck();
    run_slot(1'b1);
    run_slot(1'b0);
    check("s4_underflow", {31'd0, underflow}, 32'd1);
    run_slot(1'b1);
    run_slot(1'b0);
    check("s4_left_zero", get_word(32), 32'h00000000);
    check("s4_right_word", get_word(64), 32'h5A5A5A00);

    // Reset in the middle of a shifting slot
    do_reset();
    push(32'hFFFFFF00, 1'b0, "s5_push_l");
    push(32'h22222200, 1'b1, "s5_push_r");
    align_sck();
    run_slot(1'b1);
    for (int i = 0; i < 5; i++) sck_bit(1'b0);
    check("s5_sd_pre_rst", {31'd0, sd}, 32'd1);
    #40;
    rst_n_in = 1'b0;
    #1;
    check("s5_rst_sd", {31'd0, sd}, 32'd0);
    check("s5_rst_tready", {31'd0, s_axis_tready}, 32'd0);
    check("s5_rst_underflow", {31'd0, underflow}, 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    check("s5_rel_tready_0", {31'd0, s_axis_tready}, 32'd0);
    @(posedge clk_in);
    #1;
    check("s5_rel_tready_1", {31'd0, s_axis_tready}, 32'd1);
    rx.delete();
    align_sck();
    for (int i = 0; i < 26; i++) sck_bit(1'b0);
    run_slot(1'b1);
    run_slot(1'b0);
    check("s5_underflow", {31'd0, underflow}, 32'd1);
    check("s5_right_zero", get_word(26), 32'h00000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_transmitter.md
I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, giving the audio bits per sample; these are taken from s_axis_tdata[31:32-DATA_WIDTH].
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the sample buffer entries; it must be a power of 2 and at least 2.
REQ-003 SHALL have port clk_in, input, 1 bit: system clock; the only clock.
REQ-004 SHALL have port rst_n_in, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port s_axis_tvalid, input, 1 bit: sample valid.
REQ-006 SHALL have port s_axis_tready, output, 1 bit: buffer can accept a sample.
REQ-007 SHALL have port s_axis_tdata, input, 32 bits: left-justified sample.
REQ-008 SHALL have port s_axis_tlast, input, 1 bit: 1 means right-channel sample, 0 means left.
REQ-009 SHALL have port sck, input, 1 bit: I2S bit clock from i2s_controller; asynchronous to clk_in.
REQ-010 SHALL have port ws, input, 1 bit: I2S word select; 0 is left, 1 is right.
REQ-011 SHALL have port sd, output, 1 bit: I2S serial data to the DAC/speaker.
REQ-012 SHALL have port underflow, output, 1 bit: sticky; a slot was started with no valid data.

Function
REQ-013 SHALL synchronise sck and ws through 2 flops each, then detect sck falling edges on the synchronised sck.
REQ-014 SHALL require clk_in >= 8x sck frequency; behaviour below this ratio is undefined.
REQ-015 SHALL buffer samples in a FIFO of FIFO_DEPTH entries, each entry {tlast, tdata[31:32-DATA_WIDTH]}.
REQ-016 SHALL drive s_axis_tready = !full; a word is written on the clk_in edge where tvalid && tready.
REQ-017 SHALL, when a push and a pop occur in the same cycle with the FIFO full, accept neither; tready stays 0 and the pop proceeds.
REQ-018 SHALL, when a push and a pop occur in the same cycle with the FIFO empty, not bypass; the pop sees empty.
REQ-019 SHALL wrap the read and write pointers modulo FIFO_DEPTH, with full and empty distinguished by an extra pointer bit.
REQ-020 SHALL implement a slot FSM with states IDLE, LOAD and SHIFT.
REQ-021 SHALL start in IDLE after reset and drive sd=0 until the first ws transition is seen at an sck falling edge.
REQ-022 SHALL detect a slot boundary on an sck falling edge where the synchronised ws differs from its value at the previous falling edge, and SHALL then enter LOAD.
REQ-023 In LOAD, if the FIFO is not empty and the head tlast equals the new ws, SHALL pop the head into a 32-bit shift register as {data, zeros}.
REQ-024 In LOAD, if the FIFO is empty, SHALL load zeros and set underflow.
REQ-025 In LOAD, if the head tlast does not equal the new ws (channel mismatch), SHALL load zeros, not pop, and set underflow.
REQ-026 SHALL leave LOAD for SHIFT in 1 clk_in cycle.
REQ-027 In SHIFT, SHALL on each sck falling edge register sd <= shreg[31] and shift left with zero fill; the first falling edge after the boundary outputs the MSB (I2S one-bit delay).
REQ-028 SHALL, after 32 bits or at the next ws transition (whichever comes first), output 0 until the next boundary; an early transition re-enters LOAD.
REQ-029 SHALL update sd within 3 clk_in cycles of the sck falling edge on the sd pin.
REQ-030 SHALL clear underflow only by reset.

Reset
REQ-031 SHALL, on rst_n_in=0, immediately clear the FIFO pointers, synchronisers, shift register and FSM (to IDLE), and drive sd=0, s_axis_tready=0 and underflow=0.
REQ-032 SHALL raise s_axis_tready 1 cycle after rst_n_in deasserts.
REQ-033 SHALL discard buffered samples on reset mid-slot; the next slot is handled as from IDLE.

Configuration
REQ-034 SHALL, with macro I2S_TRANSMITTER_UNDERFLOW_COUNT_EN defined, add output underflow_count (16 bits), incremented once per underflowed or mismatched slot, saturating at 0xFFFF, and cleared by reset.
REQ-035 SHALL, without I2S_TRANSMITTER_UNDERFLOW_COUNT_EN, omit the underflow_count port and its logic; all other behaviour is identical.

Verification
REQ-036 SHALL cover this scenario: push left 0xABCDEF00 (tlast=0) and right 0x12345600 (tlast=1), run sck at clk_in/16 -> sd bits after the ws falling edge are 0xABCDEF followed by 8 zeros, then right 0x123456 followed by 8 zeros.
REQ-037 SHALL cover this scenario: push FIFO_DEPTH+1 words without sck -> tready=0 after 4 pushes, the 5th word is held off, and no data is lost.
REQ-038 SHALL cover this scenario: start sck/ws with the FIFO empty -> sd=0 for the full slot, underflow=1, and underflow_count=1 with the macro defined.
REQ-039 SHALL cover this scenario: first pushed word has tlast=1 at a left slot -> left slot outputs zeros, the word is transmitted in the following right slot, and underflow=1.
REQ-040 SHALL cover this scenario: assert rst_n_in mid-SHIFT with 2 words buffered -> sd=0 immediately, tready=1 one cycle after release, and the next slot underflows.
